// File: rtl/fsk_link_scheduler.sv
// fsk_link_scheduler
//   Time-division scheduler sharing one FSK modulator/demodulator link
//   between two word-oriented requesters. Words are accepted over
//   valid/ready, arbitrated round-robin, and shifted out MSB-first on the
//   data line that belongs to the granted channel. Each bit is held for
//   BIT_CYCLES clocks, and every frame is followed by GUARD_CYCLES idle
//   clocks.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   ch1_data/valid/ready channel 1 request handshake
//   ch2_data/valid/ready channel 2 request handshake
//   data1, data2         serial bit to modulator channel 1 / 2
//   s                    link select, 0 = channel 1, 1 = channel 2
//   busy                 high while a frame or its guard time is in progress
//   frame_done           pulse on the last clock of a frame's final bit
module fsk_link_scheduler #(
    parameter int DATA_W       = 8,
    parameter int BIT_CYCLES   = 16,
    parameter int GUARD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ch1_data,
    input  logic              ch1_valid,
    output logic              ch1_ready,
    input  logic [DATA_W-1:0] ch2_data,
    input  logic              ch2_valid,
    output logic              ch2_ready,
    output logic              data1,
    output logic              data2,
    output logic              s,
    output logic              busy,
    output logic              frame_done
);

    // cyc_cnt is shared between bit timing and guard timing.
    localparam int CNT_MAX = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [BIT_W-1:0] WORD_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               last_grant2;   // 1: channel 2 was granted last

    logic grant2, take, bit_end, frame_end, guard_end;

    // Ties go to the channel opposite the last grant.
    assign grant2    = ch2_valid && (!ch1_valid || !last_grant2);
    // rst_n gates the handshake so no ready is shown while held in reset.
    assign take      = rst_n && (state == IDLE) && (ch1_valid || ch2_valid);
    assign bit_end   = (state == SHIFT) && (cyc_cnt == BIT_LAST);
    assign frame_end = bit_end && (bit_cnt == WORD_LAST);
    assign guard_end = (state == GUARD) && (cyc_cnt == GUARD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SHIFT;
            SHIFT:   if (frame_end) state_nxt = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            GUARD:   if (guard_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ch1_ready  = take && !grant2;
        ch2_ready  = take && grant2;
        data1      = (state == SHIFT) && !s && shift_reg[DATA_W-1];
        data2      = (state == SHIFT) &&  s && shift_reg[DATA_W-1];
        busy       = (state != IDLE);
        frame_done = frame_end;
    end

    // Datapath: shift register, counters, select and arbitration history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            s           <= 1'b0;
            last_grant2 <= 1'b1;
        end else if (take) begin
            shift_reg   <= grant2 ? ch2_data : ch1_data;
            s           <= grant2;
            last_grant2 <= grant2;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                cyc_cnt   <= '0;
                shift_reg <= shift_reg << 1;
                bit_cnt   <= frame_end ? '0 : bit_cnt + BIT_W'(1);
            end else begin
                cyc_cnt   <= cyc_cnt + CNT_W'(1);
            end
        end else if (state == GUARD) begin
            cyc_cnt <= guard_end ? '0 : cyc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fsk_link_scheduler.md
Name: fsk_link_scheduler

Overview:
- Time-division scheduler that shares one FSK modulator/demodulator link between two byte-oriented requesters.
- Accepts words from channel 1 and channel 2 over valid/ready handshakes and arbitrates between them round-robin.
- Serialises the granted word MSB-first onto the modulator's data1/data2 inputs, holding each bit for a programmable number of clocks.
- Drives the channel-select line s so that the demodulator routes each frame to q1/q2.

Parameters:
- DATA_W, 8, bits per frame (word width per request).
- BIT_CYCLES, 16, clocks each bit is held on the data line; must be ≥1.
- GUARD_CYCLES, 4, idle clocks inserted after every frame; 0 is legal and means no guard.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ch1_data  input  DATA_W  channel 1 word.
- ch1_valid  input  1  channel 1 word available.
- ch1_ready  output  1  channel 1 word accepted this cycle when ch1_valid=1.
- ch2_data  input  DATA_W  channel 2 word.
- ch2_valid  input  1  channel 2 word available.
- ch2_ready  output  1  channel 2 word accepted this cycle when ch2_valid=1.
- data1  output  1  serial bit to modulator channel 1.
- data2  output  1  serial bit to modulator channel 2.
- s  output  1  modulator/demodulator select; 0 = channel 1, 1 = channel 2.
- busy  output  1  high in SHIFT and GUARD.
- frame_done  output  1  one-cycle pulse on the last clock of a frame's final bit.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state = IDLE.
  - data1, data2, s, busy, frame_done = 0.
  - All counters = 0.
  - last_grant = ch2, so channel 1 wins the first tie.
  - Reset mid-frame aborts the frame immediately; the partially sent word is discarded.
- States: IDLE, SHIFT, GUARD.
- IDLE:
  - grant = ch1 if only ch1_valid; ch2 if only ch2_valid; if both, the channel opposite last_grant.
  - chN_ready = (state==IDLE) && grant==N. This is combinational from the valids and state; no ready is asserted outside IDLE.
  - On handshake: latch the word into the shift register, set s (0 for ch1, 1 for ch2), update last_grant, set bit_cnt=0 and cyc_cnt=0, go to SHIFT.
- SHIFT:
  - The active data line (data1 if s=0, else data2) = shift_reg MSB. The other line = 0.
  - The first bit appears on the cycle after the handshake.
  - cyc_cnt counts 0..BIT_CYCLES-1. At BIT_CYCLES-1, shift left by 1, reset cyc_cnt, and increment bit_cnt.
  - When bit_cnt==DATA_W-1 and cyc_cnt==BIT_CYCLES-1: assert frame_done that cycle, then go to GUARD (or IDLE if GUARD_CYCLES==0).
- GUARD:
  - data1 = data2 = 0; s holds its value.
  - Count GUARD_CYCLES clocks, then go to IDLE.
- Timing:
  - Frame occupancy = DATA_W*BIT_CYCLES clocks in SHIFT.
  - Back-to-back acceptance period = DATA_W*BIT_CYCLES + GUARD_CYCLES + 1 clocks, where the +1 is the IDLE handshake cycle.
- s changes only on a handshake, never mid-frame. In IDLE it keeps its last value.
- chN_data is sampled only at the handshake. Changes to the inputs after that have no effect on the frame in flight.
- A valid deasserted before a handshake is not an error; nothing is latched.
- Counter widths: cyc_cnt ≥ clog2(max(BIT_CYCLES, GUARD_CYCLES, 1)); bit_cnt ≥ clog2(DATA_W).

Test Plan (DATA_W=8, BIT_CYCLES=4, GUARD_CYCLES=2):
- Reset:
  - Stimulus: hold rst_n=0 for 3 clocks with both valids=1.
  - Required: ready, data, s, busy and frame_done are all 0.
  - After release, ch1_ready=1 in the first IDLE cycle.
- Single ch1 frame:
  - Stimulus: ch1_data=0xA5, handshake at cycle T.
  - Required: data1 = 1,0,1,0,0,1,0,1, each held 4 clocks over T+1..T+32. data2=0 and s=0 throughout. frame_done=1 only at T+32. busy=1 over T+1..T+34. IDLE at T+35.
- Single ch2 frame:
  - Stimulus: ch2_data=0x3C.
  - Required: s=1 from T+1. data2 = 00111100 MSB-first. data1=0.
- Round robin:
  - Stimulus: both valid continuously, ch1=0xFF, ch2=0x00.
  - Required: grants ch1, ch2, ch1, ch2 at cycles T, T+35, T+70, T+105. s toggles only at those handshakes.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at T+10 of a ch2 frame.
  - Required: the next cycle has data2=0, s=0, busy=0.
  - After release, the aborted word is not resent unless ch2_valid is still high, in which case it is a new handshake.
- GUARD_CYCLES=0 variant:
  - Stimulus: ch1 valid held high.
  - Required: handshakes every 33 clocks, and no clock with busy=1 while data lines are forced 0.
